instr_encoder: RTL
==================

// Module: instr_encoder
// PURPOSE
//  Streaming RV64I instruction encoder: turns {op, rd, rs1, rs2, imm} requests into raw 32-bit words.
//  Inverse of the decode stage. Feeds the self-test program loader and bench instruction injectors.
//  Registered output with valid/ready on both sides. Checks immediate legality.
//  Optionally expands the LI pseudo-op into LUI+ADDIW.
// PARAMETERS
//  CNT_W  32  width of the emitted-instruction counter
// PORTS
//  clk          in   1      clock
//  reset        in   1      async, active-low; one clock; asynchronous active-low reset
//  req_valid    in   1      request present
//  req_ready    out  1      request accepted when req_valid && req_ready
//  req_op       in   op_t   operation (pipes::op_t, plus pseudo-op LI)
//  req_rd       in   5      destination register
//  req_rs1      in   5      source register 1
//  req_rs2      in   5      source register 2
//  req_imm      in   64     word_t immediate; byte offset for branches and JAL
//  out_valid    out  1      out_instr valid
//  out_ready    in   1      consumer takes word when out_valid && out_ready
//  out_instr    out  32     encoded instruction (u32)
//  out_last     out  1      last word of the current request
//  err_valid    out  1      1-cycle pulse: previous accepted request was rejected
//  err_code     out  2      enc_err_t: 0 IMM_RANGE, 1 IMM_ALIGN, 2 BAD_OP
//  instr_count  out  CNT_W  count of output handshakes; wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset values: out_valid=0, out_instr=0, out_last=0, err_valid=0, err_code=0, instr_count=0, state=S_IDLE.
//  States:
//   S_IDLE  : nothing held.
//   S_LAST  : single or last word held.
//   S_FIRST : first of two words held; second word held in pend_q.
//  req_ready = (state==S_IDLE) || (state==S_LAST && out_ready). It is 0 in S_FIRST.
//  Latency: accept at edge N gives out_valid at N+1. Back-to-back single-word throughput is 1 per cycle.
//  Accepting a legal 1-word request: next state S_LAST.
//  Accepting a legal 2-word request: next state S_FIRST.
//  S_FIRST with out_ready: out_instr<=pend_q, next state S_LAST.
//  S_LAST with out_ready and no accept: next state S_IDLE.
//  While out_valid && !out_ready: out_instr and out_last are held stable.
//  An illegal request is still consumed but emits no word.
//   err_valid pulses the cycle after accept.
//   State moves as if no request arrived (S_LAST with out_ready goes to S_IDLE).
//  Error priority: BAD_OP > IMM_ALIGN > IMM_RANGE.
//  Immediate legality rules:
//   I-type, loads, stores, JALR, ADDIW: imm in [-2048, 2047].
//   SLLI, SRLI, SRAI: imm in [0, 63]. *IW shifts: imm in [0, 31].
//   Branches: imm even, in [-4096, 4094].
//   JAL: imm even, in [-2^20, 2^20-2].
//   LUI, AUIPC: imm[11:0]==0, and imm equals sext(imm[31:0]).
//  Registers are 5-bit, so register fields are always legal.
//  Simultaneous S_LAST drain and new accept: the new word replaces the old in the same edge. No bubble.
//  Async reset asserted mid-operation:
//   Held and pending words are dropped; all outputs return to reset values.
//   No handshake completes in the reset cycle.
// CONFIGURATION
//  INSTR_ENCODER_PSEUDO_EN defined: LI rd, imm is supported.
//   If imm fits in 12 bits: 1 word, ADDI rd, x0, imm.
//   Else if imm == sext(imm[31:0]):
//    hi = (imm + 0x800) >> 12, truncated to 20 bits; lo = imm[11:0].
//    Emits LUI rd, hi, then ADDIW rd, rd, lo. If lo==0, only the LUI is emitted.
//    ADDIW 32-bit wrap makes the result exact at 0x7FFFF800..0x7FFFFFFF.
//   Otherwise: IMM_RANGE error.
//  INSTR_ENCODER_PSEUDO_EN not defined: LI gives BAD_OP. Every request is 1 word. S_FIRST and pend_q are not built.
// STRUCTURE
//  pipes package additions:
//   LI in op_t.
//   enc_err_t.
//   Opcode/funct3 constants (F7_*, F3_*), shared with the decode stage, with none duplicated locally.
//  Sub-module instr_pack: combinational {op, regs, imm} -> {u32 word, legal, err}.
//  instr_encoder holds the FSM, pend_q, the error pulse and the counter.
// TESTING
//  1. ADDI x1, x2, -1 -> 0xFFF10093 one cycle later, out_last=1, instr_count=1.
//  2. PSEUDO_EN, LI x5, 0x12345678 -> 0x123452B7 (last=0), then 0x6782829B (last=1). req_ready=0 in between.
//  3. PSEUDO_EN, LI x1, 0x7FFFFFFF -> 0x800000B7, then 0xFFF0809B.
//  4. BEQ x1, x2, imm=3 -> no out_valid, err_valid pulse with err_code=IMM_ALIGN. Then ADDI x0, x0, 0 -> 0x00000013.
//  5. out_ready=0 for 3 cycles holding 0x00000013 -> word stable, req_ready=0. out_ready=1 -> 1 handshake only.
//  6. Reset driven low while in S_FIRST -> out_valid=0, instr_count=0 asynchronously. The pending ADDIW is never emitted.

Source files
------------

// File: rtl/pipes_pkg.sv
// Shared pipeline types: op/err enums, opcode and funct constants, encoder structs.
// INSTR_ENCODER_PSEUDO_EN adds the second-word fields used by the LI expansion.
package pipes;

  typedef logic [63:0] word_t;
  typedef logic [31:0] u32;

  typedef enum logic [5:0] {
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
    OP_SB, OP_SH, OP_SW, OP_SD,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_ADDIW, OP_SLLIW, OP_SRLIW, OP_SRAIW,
    OP_ADDW, OP_SUBW, OP_SLLW, OP_SRLW, OP_SRAW,
    OP_LI
  } op_t;

  typedef enum logic [1:0] {
    ERR_IMM_RANGE = 2'd0,
    ERR_IMM_ALIGN = 2'd1,
    ERR_BAD_OP    = 2'd2
  } enc_err_t;

  typedef enum logic [1:0] {S_IDLE, S_LAST, S_FIRST} enc_state_t;

  typedef enum logic [3:0] {
    FMT_R, FMT_I, FMT_SH6, FMT_SH5, FMT_S, FMT_B, FMT_U, FMT_J, FMT_LI
  } fmt_t;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [2:0] F3_LB   = 3'b000;
  localparam logic [2:0] F3_LH   = 3'b001;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_LD   = 3'b011;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [2:0] F3_LHU  = 3'b101;
  localparam logic [2:0] F3_LWU  = 3'b110;
  localparam logic [2:0] F3_SB   = 3'b000;
  localparam logic [2:0] F3_SH   = 3'b001;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_SD   = 3'b011;

  typedef struct packed {
    op_t        op;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    word_t      imm;
  } enc_req_t;

  typedef struct packed {
    u32       word;
`ifdef INSTR_ENCODER_PSEUDO_EN
    u32       word2;
    logic     two;
`endif
    logic     legal;
    enc_err_t err;
  } pack_t;

  // True when v is representable as an n-bit two's-complement value.
  function automatic logic fits_s(word_t v, int n);
    logic signed [63:0] s, lim;
    s   = $signed(v);
    lim = 64'sd1 <<< (n - 1);
    return (s >= -lim) && (s < lim);
  endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational packer: {op, regs, imm} -> 32-bit word plus legality and error code.
// With INSTR_ENCODER_PSEUDO_EN, LI may also produce a second (ADDIW) word.
module instr_pack
  import pipes::*;
(
  input  enc_req_t req,
  output pack_t    res
);

  fmt_t       fmt;
  logic [6:0] opc;
  logic [6:0] f7;
  logic [2:0] f3;
  logic       op_ok, rng_ok, aln_ok;
`ifdef INSTR_ENCODER_PSEUDO_EN
  // (imm + 0x800) >> 12: the carry out of bit 11 rounds the upper part.
  logic [19:0] li_hi;
  assign li_hi = req.imm[31:12] + {19'd0, req.imm[11]};
`endif

  always_comb begin
    fmt = FMT_R; opc = OPC_OP; f3 = F3_ADD; f7 = F7_BASE; op_ok = 1'b1;
    case (req.op)
      OP_LUI:   begin fmt = FMT_U; opc = OPC_LUI; end
      OP_AUIPC: begin fmt = FMT_U; opc = OPC_AUIPC; end
      OP_JAL:   begin fmt = FMT_J; opc = OPC_JAL; end
      OP_JALR:  begin fmt = FMT_I; opc = OPC_JALR; f3 = F3_JALR; end
      OP_BEQ:   begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BEQ; end
      OP_BNE:   begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BNE; end
      OP_BLT:   begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BLT; end
      OP_BGE:   begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BGE; end
      OP_BLTU:  begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BLTU; end
      OP_BGEU:  begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BGEU; end
      OP_LB:    begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_LB; end
      OP_LH:    begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_LH; end
      OP_LW:    begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_LW; end
      OP_LD:    begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_LD; end
      OP_LBU:   begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_LBU; end
      OP_LHU:   begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_LHU; end
      OP_LWU:   begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_LWU; end
      OP_SB:    begin fmt = FMT_S; opc = OPC_STORE; f3 = F3_SB; end
      OP_SH:    begin fmt = FMT_S; opc = OPC_STORE; f3 = F3_SH; end
      OP_SW:    begin fmt = FMT_S; opc = OPC_STORE; f3 = F3_SW; end
      OP_SD:    begin fmt = FMT_S; opc = OPC_STORE; f3 = F3_SD; end
      OP_ADDI:  begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_ADD; end
      OP_SLTI:  begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_SLT; end
      OP_SLTIU: begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_SLTU; end
      OP_XORI:  begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_XOR; end
      OP_ORI:   begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_OR; end
      OP_ANDI:  begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_AND; end
      OP_SLLI:  begin fmt = FMT_SH6; opc = OPC_OP_IMM; f3 = F3_SLL; end
      OP_SRLI:  begin fmt = FMT_SH6; opc = OPC_OP_IMM; f3 = F3_SR; end
      OP_SRAI:  begin fmt = FMT_SH6; opc = OPC_OP_IMM; f3 = F3_SR; f7 = F7_ALT; end
      OP_ADD:   begin opc = OPC_OP; f3 = F3_ADD; end
      OP_SUB:   begin opc = OPC_OP; f3 = F3_ADD; f7 = F7_ALT; end
      OP_SLL:   begin opc = OPC_OP; f3 = F3_SLL; end
      OP_SLT:   begin opc = OPC_OP; f3 = F3_SLT; end
      OP_SLTU:  begin opc = OPC_OP; f3 = F3_SLTU; end
      OP_XOR:   begin opc = OPC_OP; f3 = F3_XOR; end
      OP_SRL:   begin opc = OPC_OP; f3 = F3_SR; end
      OP_SRA:   begin opc = OPC_OP; f3 = F3_SR; f7 = F7_ALT; end
      OP_OR:    begin opc = OPC_OP; f3 = F3_OR; end
      OP_AND:   begin opc = OPC_OP; f3 = F3_AND; end
      OP_ADDIW: begin fmt = FMT_I; opc = OPC_OP_IMM32; f3 = F3_ADD; end
      OP_SLLIW: begin fmt = FMT_SH5; opc = OPC_OP_IMM32; f3 = F3_SLL; end
      OP_SRLIW: begin fmt = FMT_SH5; opc = OPC_OP_IMM32; f3 = F3_SR; end
      OP_SRAIW: begin fmt = FMT_SH5; opc = OPC_OP_IMM32; f3 = F3_SR; f7 = F7_ALT; end
      OP_ADDW:  begin opc = OPC_OP32; f3 = F3_ADD; end
      OP_SUBW:  begin opc = OPC_OP32; f3 = F3_ADD; f7 = F7_ALT; end
      OP_SLLW:  begin opc = OPC_OP32; f3 = F3_SLL; end
      OP_SRLW:  begin opc = OPC_OP32; f3 = F3_SR; end
      OP_SRAW:  begin opc = OPC_OP32; f3 = F3_SR; f7 = F7_ALT; end
`ifdef INSTR_ENCODER_PSEUDO_EN
      OP_LI:    fmt = FMT_LI;
`endif
      default:  op_ok = 1'b0;
    endcase
  end

  always_comb begin
    res    = '0;
    rng_ok = 1'b1;
    aln_ok = 1'b1;
    case (fmt)
      FMT_R:   res.word = {f7, req.rs2, req.rs1, f3, req.rd, opc};
      FMT_I: begin
        res.word = {req.imm[11:0], req.rs1, f3, req.rd, opc};
        rng_ok   = fits_s(req.imm, 12);
      end
      FMT_SH6: begin
        res.word = {f7[6:1], req.imm[5:0], req.rs1, f3, req.rd, opc};
        rng_ok   = (req.imm[63:6] == '0);
      end
      FMT_SH5: begin
        res.word = {f7, req.imm[4:0], req.rs1, f3, req.rd, opc};
        rng_ok   = (req.imm[63:5] == '0);
      end
      FMT_S: begin
        res.word = {req.imm[11:5], req.rs2, req.rs1, f3, req.imm[4:0], opc};
        rng_ok   = fits_s(req.imm, 12);
      end
      FMT_B: begin
        res.word = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, f3,
                    req.imm[4:1], req.imm[11], opc};
        aln_ok   = ~req.imm[0];
        rng_ok   = fits_s(req.imm, 13);
      end
      FMT_U: begin
        // Low 12 bits must be clear: the immediate is the final 4 KiB-aligned value.
        res.word = {req.imm[31:12], req.rd, opc};
        aln_ok   = (req.imm[11:0] == 12'd0);
        rng_ok   = fits_s(req.imm, 32);
      end
      FMT_J: begin
        res.word = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12], req.rd, opc};
        aln_ok   = ~req.imm[0];
        rng_ok   = fits_s(req.imm, 21);
      end
`ifdef INSTR_ENCODER_PSEUDO_EN
      FMT_LI: begin
        if (fits_s(req.imm, 12)) begin
          res.word = {req.imm[11:0], 5'd0, F3_ADD, req.rd, OPC_OP_IMM};
        end else if (fits_s(req.imm, 32)) begin
          res.word = {li_hi, req.rd, OPC_LUI};
          if (req.imm[11:0] != 12'd0) begin
            res.two   = 1'b1;
            res.word2 = {req.imm[11:0], req.rd, F3_ADD, req.rd, OPC_OP_IMM32};
          end
        end else begin
          rng_ok = 1'b0;
        end
      end
`endif
      default: ;
    endcase

    res.legal = op_ok & aln_ok & rng_ok;
    if (!op_ok)       res.err = ERR_BAD_OP;
    else if (!aln_ok) res.err = ERR_IMM_ALIGN;
    else              res.err = ERR_IMM_RANGE;
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV64I encoder: registered valid/ready output, error pulse, handshake counter.
// INSTR_ENCODER_PSEUDO_EN enables LI expansion into LUI+ADDIW via S_FIRST and pend_q.
module instr_encoder
  import pipes::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  op_t              req_op,
  input  logic [4:0]       req_rd,
  input  logic [4:0]       req_rs1,
  input  logic [4:0]       req_rs2,
  input  word_t            req_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output u32               out_instr,
  output logic             out_last,
  output logic             err_valid,
  output enc_err_t         err_code,
  output logic [CNT_W-1:0] instr_count
);

  enc_state_t state, nstate;
  enc_req_t   rq;
  pack_t      pk;
  logic       accept, load, two;

  assign rq = '{op: req_op, rd: req_rd, rs1: req_rs1, rs2: req_rs2, imm: req_imm};

  instr_pack u_pack (.req(rq), .res(pk));

`ifdef INSTR_ENCODER_PSEUDO_EN
  u32 pend_q;
  assign two = pk.two;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    pend_q <= '0;
    else if (load) pend_q <= pk.word2;
  end
`else
  assign two = 1'b0;
`endif

  assign req_ready = (state == S_IDLE) || (state == S_LAST && out_ready);
  assign out_valid = (state != S_IDLE);
  assign accept    = req_valid && req_ready;
  assign load      = accept && pk.legal;

  // An illegal accept is consumed silently: the FSM moves as if nothing arrived.
  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:  if (load) nstate = two ? S_FIRST : S_LAST;
      S_LAST:  if (out_ready) nstate = load ? (two ? S_FIRST : S_LAST) : S_IDLE;
      S_FIRST: if (out_ready) nstate = S_LAST;
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      out_instr   <= '0;
      out_last    <= 1'b0;
      err_valid   <= 1'b0;
      err_code    <= ERR_IMM_RANGE;
      instr_count <= '0;
    end else begin
      state     <= nstate;
      err_valid <= accept && !pk.legal;
      if (accept && !pk.legal) err_code <= pk.err;
      if (out_valid && out_ready) instr_count <= instr_count + CNT_W'(1);
      if (load) begin
        out_instr <= pk.word;
        out_last  <= ~two;
      end
`ifdef INSTR_ENCODER_PSEUDO_EN
      else if (state == S_FIRST && out_ready) begin
        out_instr <= pend_q;
        out_last  <= 1'b1;
      end
`endif
    end
  end

endmodule
